// File: rtl/serpent_pkg.sv
// Shared types, constants and helpers for the iterative Serpent-128 decryptor.
// Block layout everywhere is {x3,x2,x1,x0}; nibble j is {x3[j],x2[j],x1[j],x0[j]}.
package serpent_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUND,
    ILT,
    DONE
  } state_t;

  localparam int unsigned NUM_ROUNDS = 32;
  localparam int unsigned LAST_KEY   = 32;

  // Inverse S-boxes SI0..SI7; entry v lives in nibble v (bits 4v+3:4v).
  localparam logic [63:0] SI_TAB [8] = '{
    64'h289f74e1c56a0b3d,
    64'h0ad1974b3c6fe285,
    64'h7a85d63021eb4f9c,
    64'h1f842c53d6eb7a90,
    64'h1df46bc2e79a3805,
    64'h0ac7356bed1492f8,
    64'hb8c27e940635d1af,
    64'h241a7bc58fe9d603
  };

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] ilt(input logic [127:0] b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x2 = ror32(x2, 22);
    x0 = ror32(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = ror32(x3, 7);
    x1 = ror32(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = ror32(x2, 3);
    x0 = ror32(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

endpackage

// File: rtl/serpent_decrypt_core_sbox.sv
// Combinational bitslice inverse S-box SI_IDX applied to all 32 nibble columns.
module serpent_inv_sbox
  import serpent_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x3,
  output logic [31:0] y0,
  output logic [31:0] y1,
  output logic [31:0] y2,
  output logic [31:0] y3
);

  localparam logic [63:0] TAB = SI_TAB[IDX];

  logic [3:0] nib;
  logic [3:0] sub;

  always_comb begin
    y0  = '0;
    y1  = '0;
    y2  = '0;
    y3  = '0;
    nib = '0;
    sub = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      nib   = {x3[j], x2[j], x1[j], x0[j]};
      sub   = TAB[{nib, 2'b00} +: 4];
      y0[j] = sub[0];
      y1[j] = sub[1];
      y2[j] = sub[2];
      y3[j] = sub[3];
    end
  end

endmodule

// File: rtl/serpent_decrypt_core.sv
// Iterative Serpent-128 block decryptor: one inverse round per cycle (two with SPLIT_ROUND),
// subkeys fetched through a zero-latency indexed read port.
module serpent_decrypt_core
  import serpent_pkg::*;
#(
  parameter int unsigned KEY_IDX_W   = 6,
  parameter bit          SPLIT_ROUND = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          c0,
  input  logic [31:0]          c1,
  input  logic [31:0]          c2,
  input  logic [31:0]          c3,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         key_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          p0,
  output logic [31:0]          p1,
  output logic [31:0]          p2,
  output logic [31:0]          p3
);

  state_t         state_q, state_d;
  logic [4:0]     r_q, r_d;
  logic [127:0]   b_q, b_d;
  logic [127:0]   t_q, t_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [5:0]     key_sel;
  logic [127:0]   sb_in, sb_out;
  logic [31:0]    si_y0 [8];
  logic [31:0]    si_y1 [8];
  logic [31:0]    si_y2 [8];
  logic [31:0]    si_y3 [8];

  // Round 31 has no linear transform to undo; later rounds take ILT either inline or from t_q.
  assign sb_in = (r_q == 5'd31) ? b_q : (SPLIT_ROUND ? t_q : ilt(b_q));

  for (genvar g = 0; g < 8; g++) begin : g_si
    serpent_inv_sbox #(.IDX(g)) u_si (
      .x0(sb_in[31:0]),
      .x1(sb_in[63:32]),
      .x2(sb_in[95:64]),
      .x3(sb_in[127:96]),
      .y0(si_y0[g]),
      .y1(si_y1[g]),
      .y2(si_y2[g]),
      .y3(si_y3[g])
    );
  end

  assign sb_out = {si_y3[r_q[2:0]], si_y2[r_q[2:0]], si_y1[r_q[2:0]], si_y0[r_q[2:0]]};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    b_d     = b_q;
    t_d     = t_q;
    key_sel = 6'(LAST_KEY);
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          b_d     = {c3, c2, c1, c0} ^ key_in;
          r_d     = 5'(NUM_ROUNDS - 1);
          state_d = RUND;
        end
      end
      RUND: begin
        key_sel = {1'b0, r_q};
        b_d     = sb_out ^ key_in;
        if (r_q == 5'd0) begin
          state_d = DONE;
        end else begin
          r_d     = r_q - 5'd1;
          state_d = SPLIT_ROUND ? ILT : RUND;
        end
      end
      ILT: begin
        key_sel = {1'b0, r_q};
        t_d     = ilt(b_q);
        state_d = RUND;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= 5'(NUM_ROUNDS - 1);
      b_q         <= '0;
      t_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      b_q         <= b_d;
      t_q         <= t_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign key_idx          = KEY_IDX_W'(key_sel);
  assign {p3, p2, p1, p0} = b_q;

endmodule
